// File: rtl/simd_arb_pkg.sv
// simd_arb_pkg
// Shared types and default sizes for the SIMD engine arbiter slice.
//   state_t : sequencer states (2-bit encoding)
//   pix_t   : one 8-bit pixel / Q0.8 weight lane
//   N_LANES : default SIMD lane count per batch
//   N_REQ   : default number of batch requesters
package simd_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  typedef logic [7:0] pix_t;

  localparam int N_LANES = 4;
  localparam int N_REQ   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick. The search starts at the requester
// just after `last` and wraps around, so `last` itself has lowest priority.
//   req       : request vector, one bit per requester
//   last      : index of the most recently served requester
//   grant     : one-hot winner (all zero when no request is pending)
//   grant_idx : encoded winner index (0 when no request is pending)
module rr_arbiter
  import simd_arb_pkg::*;
#(
  parameter int R = N_REQ
) (
  input  logic [R-1:0]         req,
  input  logic [$clog2(R)-1:0] last,
  output logic [R-1:0]         grant,
  output logic [$clog2(R)-1:0] grant_idx
);

  localparam int IW = $clog2(R);

  logic          found;
  logic [IW-1:0] cand;

  // Walk offsets 1..R from `last`; the first asserted requester wins and the
  // `found` flag masks every later candidate.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= R; i++) begin
      cand = IW'((int'(last) + i) % R);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) begin
      grant = R'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/simd_engine_arbiter.sv
// simd_engine_arbiter
// Shares one bilinear SIMD engine between R batch requesters. A round-robin
// winner's operand batch is captured into the engine operand registers, the
// engine is started, and its N result pixels are routed back to the winner.
// A watchdog turns a silent engine into a sticky fault.
//   clk, rst           : clock and synchronous active-low reset
//   req / req_*        : per-requester request and N-lane operand vectors
//   gnt                : one-hot pulse, batch captured this cycle
//   resp_valid         : one-hot pulse, resp_pixel valid for that requester
//   resp_pixel         : shared N-lane result bus
//   resp_err           : timeout marker accompanying resp_valid
//   busy, fault        : not-idle status and sticky timeout flag
//   eng_start / eng_*  : start pulse and registered operands to the engine
//   eng_done/eng_pixel : engine completion strobe and results
module simd_engine_arbiter
  import simd_arb_pkg::*;
#(
  parameter int N        = N_LANES,
  parameter int R        = N_REQ,
  parameter int MAX_WAIT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [R-1:0]           req,
  input  pix_t [R-1:0][N-1:0]    req_I00,
  input  pix_t [R-1:0][N-1:0]    req_I10,
  input  pix_t [R-1:0][N-1:0]    req_I01,
  input  pix_t [R-1:0][N-1:0]    req_I11,
  input  pix_t [R-1:0][N-1:0]    req_alpha,
  input  pix_t [R-1:0][N-1:0]    req_beta,
  output logic [R-1:0]           gnt,
  output logic [R-1:0]           resp_valid,
  output pix_t [N-1:0]           resp_pixel,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   fault,
  output logic                   eng_start,
  output pix_t [N-1:0]           eng_I00,
  output pix_t [N-1:0]           eng_I10,
  output pix_t [N-1:0]           eng_I01,
  output pix_t [N-1:0]           eng_I11,
  output pix_t [N-1:0]           eng_alpha,
  output pix_t [N-1:0]           eng_beta,
  input  logic                   eng_done,
  input  pix_t [N-1:0]           eng_pixel
);

  localparam int            IW      = $clog2(R);
  localparam int            WW      = $clog2(MAX_WAIT);
  localparam logic [WW-1:0] WD_LAST = WW'(MAX_WAIT - 1);

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] cur_idx;
  logic [R-1:0]  cur_gnt;
  logic [WW-1:0] wd;

  logic [R-1:0]  win_grant;
  logic [IW-1:0] win_idx;

  rr_arbiter #(.R(R)) u_rr (
    .req       (req),
    .last      (last),
    .grant     (win_grant),
    .grant_idx (win_idx)
  );

  // Single sequencer FSM. gnt, resp_valid, resp_err and eng_start are pulses,
  // so they default low every cycle and are raised only by their transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last       <= IW'(R - 1);
      cur_idx    <= '0;
      cur_gnt    <= '0;
      wd         <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_pixel <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      eng_start  <= 1'b0;
      eng_I00    <= '0;
      eng_I10    <= '0;
      eng_I01    <= '0;
      eng_I11    <= '0;
      eng_alpha  <= '0;
      eng_beta   <= '0;
    end else begin
      gnt        <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      eng_start  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (|req) begin
            eng_I00   <= req_I00[win_idx];
            eng_I10   <= req_I10[win_idx];
            eng_I01   <= req_I01[win_idx];
            eng_I11   <= req_I11[win_idx];
            eng_alpha <= req_alpha[win_idx];
            eng_beta  <= req_beta[win_idx];
            gnt       <= win_grant;
            cur_gnt   <= win_grant;
            cur_idx   <= win_idx;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        // A done arriving here belongs to nothing we issued and is dropped.
        S_ISSUE: begin
          eng_start <= 1'b1;
          wd        <= '0;
          state     <= S_WAIT;
        end

        // A done in the same cycle the watchdog expires still counts as a
        // normal completion. The count cannot pass WD_LAST because reaching
        // it always leaves the state, so the counter never wraps.
        S_WAIT: begin
          if (eng_done) begin
            resp_pixel <= eng_pixel;
            resp_valid <= cur_gnt;
            last       <= cur_idx;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else if (wd == WD_LAST) begin
            resp_pixel <= '0;
            resp_valid <= cur_gnt;
            resp_err   <= 1'b1;
            fault      <= 1'b1;
            state      <= S_FAULT;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        // Terminal until reset; busy stays high so requesters see the stall.
        S_FAULT: begin
          state <= S_FAULT;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simd_engine_arbiter.sv
// tb_simd_engine_arbiter
// Directed bench for simd_engine_arbiter with a behavioural bilinear engine
// and a scoreboard queue of expected responses in service order.
module tb_simd_engine_arbiter;

  localparam int N        = 4;
  localparam int R        = 2;
  localparam int MAX_WAIT = 8;

  typedef struct {
    int                idx;
    logic              err;
    logic [N-1:0][7:0] pix;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [R-1:0]            req;
  logic [R-1:0][N-1:0][7:0] req_I00, req_I10, req_I01, req_I11, req_alpha, req_beta;
  logic [R-1:0]            gnt, resp_valid;
  logic [N-1:0][7:0]       resp_pixel;
  logic                    resp_err, busy, fault, eng_start;
  logic [N-1:0][7:0]       eng_I00, eng_I10, eng_I01, eng_I11, eng_alpha, eng_beta;
  logic                    eng_done;
  logic [N-1:0][7:0]       eng_pixel;

  logic              model_done = 1'b0;
  logic              stray_done = 1'b0;
  logic              pend       = 1'b0;
  logic [N-1:0][7:0] model_pix  = '0;
  int                cnt        = 0;
  int                eng_lat    = 3;
  logic              eng_mute   = 1'b0;

  int   nChecks = 0;
  int   nFails  = 0;
  exp_t sb[$];
  int   remain[R];
  bit   strayOnGrant = 1'b0;
  bit   pulseOnStart = 1'b0;
  bit   pulseActive  = 1'b0;

  simd_engine_arbiter #(.N(N), .R(R), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_I00    (req_I00),
    .req_I10    (req_I10),
    .req_I01    (req_I01),
    .req_I11    (req_I11),
    .req_alpha  (req_alpha),
    .req_beta   (req_beta),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_pixel (resp_pixel),
    .resp_err   (resp_err),
    .busy       (busy),
    .fault      (fault),
    .eng_start  (eng_start),
    .eng_I00    (eng_I00),
    .eng_I10    (eng_I10),
    .eng_I01    (eng_I01),
    .eng_I11    (eng_I11),
    .eng_alpha  (eng_alpha),
    .eng_beta   (eng_beta),
    .eng_done   (eng_done),
    .eng_pixel  (eng_pixel)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bilin(input logic [7:0] p00, input logic [7:0] p10,
                                       input logic [7:0] p01, input logic [7:0] p11,
                                       input logic [7:0] a, input logic [7:0] b);
    int top, bot, res;
    top = (int'(p00) * (256 - int'(a)) + int'(p10) * int'(a)) / 256;
    bot = (int'(p01) * (256 - int'(a)) + int'(p11) * int'(a)) / 256;
    res = (top * (256 - int'(b)) + bot * int'(b)) / 256;
    return 8'(res);
  endfunction

  function automatic logic [R-1:0] oh(input int k);
    return R'(1) << k;
  endfunction

  // Behavioural engine: latches the operands on the start pulse and answers
  // eng_lat cycles later, unless muted to provoke a timeout.
  assign eng_done  = model_done | stray_done;
  assign eng_pixel = model_pix;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (!rst) begin
      pend <= 1'b0;
    end else if (eng_start && !eng_mute) begin
      pend <= 1'b1;
      cnt  <= eng_lat;
      for (int l = 0; l < N; l++)
        model_pix[l] <= bilin(eng_I00[l], eng_I10[l], eng_I01[l], eng_I11[l],
                              eng_alpha[l], eng_beta[l]);
    end else if (pend) begin
      if (cnt <= 1) begin
        model_done <= 1'b1;
        pend       <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loads a batch for requester k (mode 0 = fixed half-way pattern, 1 = random),
  // raises its request and queues the response it should eventually receive.
  task automatic applyStimulus(input int k, input int mode, input bit expErr);
    exp_t e;
    logic [7:0] p00, p10, p01, p11, a, b;
    e.idx = k;
    e.err = expErr;
    for (int l = 0; l < N; l++) begin
      if (mode == 0) begin
        p00 = 8'd10; p10 = 8'd30; p01 = 8'd0; p11 = 8'd0; a = 8'h80; b = 8'h00;
      end else begin
        p00 = 8'($urandom); p10 = 8'($urandom); p01 = 8'($urandom);
        p11 = 8'($urandom); a   = 8'($urandom); b   = 8'($urandom);
      end
      req_I00[k][l]   = p00;
      req_I10[k][l]   = p10;
      req_I01[k][l]   = p01;
      req_I11[k][l]   = p11;
      req_alpha[k][l] = a;
      req_beta[k][l]  = b;
      e.pix[l] = expErr ? 8'h00 : bilin(p00, p10, p01, p11, a, b);
    end
    sb.push_back(e);
    req[k] = 1'b1;
  endtask

  // Plays the requester side: on each grant checks the winner against the
  // queue head and either reloads or drops that request; on each response
  // pops the queue and checks routing, pixels and the error flag.
  task automatic runBatches(input int nResp, input int budget);
    int   got;
    int   cycles;
    int   k;
    exp_t e;
    got    = 0;
    cycles = 0;
    while (got < nResp && cycles < budget) begin
      @(negedge clk);
      cycles++;
      stray_done = 1'b0;
      if (pulseActive) begin
        req[1]      = 1'b0;
        pulseActive = 1'b0;
      end
      if (gnt !== '0) begin
        if (sb.size() == 0) begin
          checkOutput("gnt_unexpected", 64'(gnt), 64'd0);
        end else begin
          k = sb[0].idx;
          checkOutput("gnt_order", 64'(gnt), 64'(oh(k)));
          remain[k]--;
          if (remain[k] > 0) applyStimulus(k, 1, 1'b0);
          else req[k] = 1'b0;
          if (strayOnGrant) begin
            stray_done   = 1'b1;
            strayOnGrant = 1'b0;
          end
        end
      end
      if (eng_start === 1'b1 && pulseOnStart) begin
        req[1]       = 1'b1;
        pulseActive  = 1'b1;
        pulseOnStart = 1'b0;
      end
      if (resp_valid !== '0) begin
        if (sb.size() == 0) begin
          checkOutput("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("resp_onehot", 64'(resp_valid), 64'(oh(e.idx)));
          checkOutput("resp_pixel", 64'(resp_pixel), 64'(e.pix));
          checkOutput("resp_err", 64'(resp_err), 64'(e.err));
        end
        got++;
      end
    end
    if (got < nResp) checkOutput("resp_budget", 64'(got), 64'(nResp));
  endtask

  task automatic quiet(input string tag, input int n);
    logic [R-1:0] acc;
    acc = '0;
    repeat (n) begin
      @(negedge clk);
      acc = acc | gnt | resp_valid;
    end
    checkOutput(tag, 64'(acc), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_gnt"}, 64'(gnt), 64'd0);
    checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    checkOutput({tag, "_flags"}, 64'({resp_err, busy, fault, eng_start}), 64'd0);
    checkOutput({tag, "_resp_pixel"}, 64'(resp_pixel), 64'd0);
    checkOutput({tag, "_eng_ops"},
                64'(eng_I00 | eng_I10 | eng_I01 | eng_I11 | eng_alpha | eng_beta), 64'd0);
  endtask

  initial begin
    logic [R-1:0] accG;
    logic         accS;
    exp_t         e;

    rst        = 1'b0;
    req        = '0;
    req_I00    = '0;
    req_I10    = '0;
    req_I01    = '0;
    req_I11    = '0;
    req_alpha  = '0;
    req_beta   = '0;
    remain     = '{0, 0};

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;

    $display("[TB] contention, both requesters for two batches each");
    remain = '{2, 2};
    applyStimulus(0, 1, 1'b0);
    applyStimulus(1, 1, 1'b0);
    runBatches(4, 200);
    quiet("contention_quiet", 3);

    $display("[TB] single request, latency and pass-through");
    applyStimulus(0, 0, 1'b0);
    @(negedge clk);
    checkOutput("single_gnt", 64'(gnt), 64'(2'b01));
    req[0] = 1'b0;
    checkOutput("single_ops", 64'({eng_alpha, eng_I10}), {32'h80808080, 32'h1e1e1e1e});
    @(negedge clk);
    checkOutput("single_start", 64'({gnt, eng_start}), 64'(3'b001));
    checkOutput("single_expect20", 64'(sb[0].pix), 64'(32'h14141414));
    runBatches(1, 30);

    $display("[TB] withdrawal of requester 1 during WAIT");
    remain[0]    = 1;
    pulseOnStart = 1'b1;
    applyStimulus(0, 1, 1'b0);
    runBatches(1, 40);
    pulseOnStart = 1'b0;
    quiet("withdraw_no_gnt", 4);
    checkOutput("withdraw_busy", 64'(busy), 64'd0);

    $display("[TB] stray done in IDLE and ISSUE");
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    quiet("stray_idle", 3);
    strayOnGrant = 1'b1;
    remain[1]    = 1;
    applyStimulus(1, 1, 1'b0);
    runBatches(1, 40);
    stray_done = 1'b0;
    quiet("stray_extra", 4);

    $display("[TB] watchdog timeout");
    eng_mute = 1'b1;
    applyStimulus(0, 1, 1'b1);
    @(negedge clk);
    checkOutput("timeout_gnt", 64'(gnt), 64'(2'b01));
    req[0] = 1'b0;
    @(negedge clk);
    checkOutput("timeout_start", 64'(eng_start), 64'd1);
    accG = '0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      @(negedge clk);
      if (i < MAX_WAIT) accG = accG | resp_valid;
    end
    checkOutput("timeout_early", 64'(accG), 64'd0);
    e = sb.pop_front();
    checkOutput("timeout_valid", 64'(resp_valid), 64'(oh(e.idx)));
    checkOutput("timeout_err", 64'(resp_err), 64'(e.err));
    checkOutput("timeout_pixel", 64'(resp_pixel), 64'(e.pix));
    checkOutput("timeout_fault", 64'(fault), 64'd1);
    req  = 2'b11;
    accG = '0;
    accS = 1'b0;
    repeat (10) begin
      @(negedge clk);
      accG = accG | gnt | resp_valid;
      accS = accS | eng_start;
    end
    checkOutput("fault_no_gnt", 64'(accG), 64'd0);
    checkOutput("fault_no_start", 64'(accS), 64'd0);
    checkOutput("fault_sticky", 64'({fault, busy}), 64'(2'b11));
    req = '0;

    $display("[TB] reset out of FAULT");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkResetValues("fault_reset");
    eng_mute = 1'b0;
    sb.delete();

    remain[0] = 1;
    applyStimulus(0, 1, 1'b0);
    runBatches(1, 40);

    $display("[TB] reset in the middle of WAIT");
    eng_mute = 1'b1;
    applyStimulus(1, 1, 1'b0);
    @(negedge clk);
    checkOutput("midwait_gnt", 64'(gnt), 64'(2'b10));
    req[1] = 1'b0;
    @(negedge clk);
    checkOutput("midwait_start", 64'(eng_start), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkResetValues("midwait_reset");
    sb.delete();
    eng_mute = 1'b0;

    remain = '{1, 1};
    applyStimulus(0, 1, 1'b0);
    applyStimulus(1, 1, 1'b0);
    runBatches(2, 100);
    quiet("final_quiet", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
